// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the data-memory access path: width codes, FSM
// encoding, bus lane payload and the access-legality predicate.
package cpu_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [2:0] FUN3_B  = 3'b000;
    localparam logic [2:0] FUN3_H  = 3'b001;
    localparam logic [2:0] FUN3_W  = 3'b010;
    localparam logic [2:0] FUN3_BU = 3'b100;
    localparam logic [2:0] FUN3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } bus_lane_t;

    // True when the access must be refused: misaligned, or an undefined width code.
    function automatic logic access_bad(input logic [2:0] fun3, input logic [1:0] lane);
        logic bad;
        case (fun3)
            FUN3_B, FUN3_BU: bad = 1'b0;
            FUN3_H, FUN3_HU: bad = lane[0];
            FUN3_W:          bad = (lane != 2'b00);
            default:         bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational datapath: store lane replication/byte enables and load
// lane select with sign or zero extension.
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  logic              st_we,
    input  logic [2:0]        st_fun3,
    input  logic [1:0]        st_lane,
    input  logic [DATA_W-1:0] st_wdata,
    output bus_lane_t         st_cmd_c,
    input  logic [2:0]        ld_fun3,
    input  logic [1:0]        ld_lane,
    input  logic [DATA_W-1:0] ld_word,
    output logic [DATA_W-1:0] ld_data_c
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Byte enables follow the access width for both loads and stores; loads drive no data.
    always_comb begin
        st_cmd_c = '0;
        case (st_fun3)
            FUN3_B, FUN3_BU: begin
                st_cmd_c.be    = 4'b0001 << st_lane;
                st_cmd_c.wdata = {4{st_wdata[7:0]}};
            end
            FUN3_H, FUN3_HU: begin
                st_cmd_c.be    = 4'b0011 << {st_lane[1], 1'b0};
                st_cmd_c.wdata = {2{st_wdata[15:0]}};
            end
            FUN3_W: begin
                st_cmd_c.be    = 4'b1111;
                st_cmd_c.wdata = st_wdata;
            end
            default: st_cmd_c = '0;
        endcase
        if (!st_we) begin
            st_cmd_c.wdata = '0;
        end
    end

    always_comb begin
        ld_byte = 8'h00;
        case (ld_lane)
            2'd0: ld_byte = ld_word[7:0];
            2'd1: ld_byte = ld_word[15:8];
            2'd2: ld_byte = ld_word[23:16];
            2'd3: ld_byte = ld_word[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
    end

    always_comb begin
        ld_data_c = '0;
        case (ld_fun3)
            FUN3_B:  ld_data_c = {{24{ld_byte[7]}}, ld_byte};
            FUN3_BU: ld_data_c = {24'h000000, ld_byte};
            FUN3_H:  ld_data_c = {{16{ld_half[15]}}, ld_half};
            FUN3_HU: ld_data_c = {16'h0000, ld_half};
            FUN3_W:  ld_data_c = ld_word;
            default: ld_data_c = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access sequencer: turns a CPU load/store request into a
// req/ack bus transaction with alignment checks and an ack timeout.
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_fun3,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              MIO_ready,
    output logic              mem_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [BE_W-1:0]   bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    state_t            state, state_nx;
    logic              lat_we, lat_we_d;
    logic [2:0]        lat_fun3, lat_fun3_d;
    logic [1:0]        lat_lane, lat_lane_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              bus_req_d, bus_we_d, ready_d, err_d;
    logic [ADDR_W-1:0] bus_addr_d;
    logic [BE_W-1:0]   bus_be_d;
    logic [DATA_W-1:0] bus_wdata_d, rdata_d;
    bus_lane_t         st_cmd_c;
    logic [DATA_W-1:0] ld_data_c;
    logic              bad_c, timeout_c;

    mem_lane_align u_align (
        .st_we     (cpu_we),
        .st_fun3   (cpu_fun3),
        .st_lane   (cpu_addr[1:0]),
        .st_wdata  (cpu_wdata),
        .st_cmd_c  (st_cmd_c),
        .ld_fun3   (lat_fun3),
        .ld_lane   (lat_lane),
        .ld_word   (bus_rdata),
        .ld_data_c (ld_data_c)
    );

    assign bad_c     = access_bad(cpu_fun3, cpu_addr[1:0]);
    // Ack in the final waiting cycle takes priority over the timeout.
    assign timeout_c = (TIMEOUT != 0) && !bus_ack && (cnt == CNT_W'(TIMEOUT - 32'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (cpu_req) state_nx = bad_c ? ST_DONE : ST_REQ;
            ST_REQ:  if (bus_ack || timeout_c) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_req_d   = bus_req;
        bus_we_d    = bus_we;
        bus_addr_d  = bus_addr;
        bus_be_d    = bus_be;
        bus_wdata_d = bus_wdata;
        rdata_d     = cpu_rdata;
        ready_d     = 1'b0;
        err_d       = mem_err;
        lat_we_d    = lat_we;
        lat_fun3_d  = lat_fun3;
        lat_lane_d  = lat_lane;
        cnt_d       = cnt;
        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    lat_we_d   = cpu_we;
                    lat_fun3_d = cpu_fun3;
                    lat_lane_d = cpu_addr[1:0];
                    if (bad_c) begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = cpu_we;
                        bus_addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
                        bus_be_d    = st_cmd_c.be;
                        bus_wdata_d = st_cmd_c.wdata;
                        cnt_d       = '0;
                    end
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    ready_d   = 1'b1;
                    err_d     = 1'b0;
                    if (!lat_we) rdata_d = ld_data_c;
                end else if (timeout_c) begin
                    bus_req_d = 1'b0;
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            cpu_rdata <= '0;
            MIO_ready <= 1'b0;
            mem_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_fun3  <= '0;
            lat_lane  <= '0;
            cnt       <= '0;
        end else begin
            bus_req   <= bus_req_d;
            bus_we    <= bus_we_d;
            bus_addr  <= bus_addr_d;
            bus_be    <= bus_be_d;
            bus_wdata <= bus_wdata_d;
            cpu_rdata <= rdata_d;
            MIO_ready <= ready_d;
            mem_err   <= err_d;
            lat_we    <= lat_we_d;
            lat_fun3  <= lat_fun3_d;
            lat_lane  <= lat_lane_d;
            cnt       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner cases plus
// randomized accesses against an arithmetic reference model.
module tb_mem_access_unit;

    localparam int unsigned ADDR_W = 32;
    localparam int          TO     = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [2:0]        cpu_fun3 = 3'b000;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [31:0]       cpu_wdata = '0;
    logic [31:0]       cpu_rdata;
    logic              MIO_ready;
    logic              mem_err;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata = '0;
    logic              bus_ack = 1'b0;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_rdata = '0;

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_fun3(cpu_fun3), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .MIO_ready(MIO_ready), .mem_err(mem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: sizes in bytes, offsets rounded down to the access width.
    function automatic int nbytes(input logic [2:0] f);
        return (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_bad(input logic [2:0] f, input logic [31:0] a);
        int lane;
        if (f == 3'b011 || f == 3'b110 || f == 3'b111) return 1'b1;
        lane = int'(a & 32'd3);
        return (lane % nbytes(f)) != 0;
    endfunction

    function automatic int lane_off(input logic [2:0] f, input logic [31:0] a);
        int lane;
        lane = int'(a & 32'd3);
        return lane - (lane % nbytes(f));
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f, input logic [31:0] a);
        int nb;
        logic [7:0] m;
        nb = nbytes(f);
        m = 8'((1 << nb) - 1) << lane_off(f, a);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic we, input logic [2:0] f, input logic [31:0] d);
        int nb;
        logic [63:0] mask, v, r;
        if (!we) return 32'h0;
        nb = nbytes(f);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v = 64'(d) & mask;
        r = '0;
        for (int i = 0; i < 4 / nb; i++) r = r | (v << (8 * nb * i));
        return r[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
        int nb;
        logic [63:0] mask, v;
        nb = nbytes(f);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v = (64'(w) >> (8 * lane_off(f, a))) & mask;
        if (!f[2] && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // One full access, entered and left on a falling edge with the unit idle.
    // ack_at: REQ cycle (0-based) in which ack is driven; <0 means never.
    task automatic access(input logic we, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] word, input int ack_at,
                          input string tag);
        int   n;
        logic err_e;
        cpu_req = 1'b1; cpu_we = we; cpu_fun3 = f; cpu_addr = a; cpu_wdata = d;
        bus_rdata = word;
        @(negedge clk);
        if (model_bad(f, a)) begin
            chk({tag, ".rdy"}, 32'(MIO_ready), 32'd1);
            chk({tag, ".err"}, 32'(mem_err), 32'd1);
            chk({tag, ".nobus"}, 32'(bus_req), 32'd0);
            cpu_req = 1'b0;
            @(negedge clk);
            chk({tag, ".pulse"}, 32'(MIO_ready), 32'd0);
            chk({tag, ".nobus2"}, 32'(bus_req), 32'd0);
        end else begin
            err_e = !(ack_at >= 0 && ack_at < TO);
            n = err_e ? TO : ack_at + 1;
            for (int k = 0; k < n; k++) begin
                chk({tag, ".req"}, 32'(bus_req), 32'd1);
                chk({tag, ".rdy0"}, 32'(MIO_ready), 32'd0);
                chk({tag, ".addr"}, bus_addr, a & 32'hFFFF_FFFC);
                chk({tag, ".be"}, 32'(bus_be), 32'(model_be(f, a)));
                chk({tag, ".wd"}, bus_wdata, model_wdata(we, f, d));
                if (k == 0) chk({tag, ".we"}, 32'(bus_we), 32'(we));
                bus_ack = (k == ack_at);
                @(negedge clk);
            end
            bus_ack = 1'b0;
            if (err_e) exp_rdata = 32'h0;
            else if (!we) exp_rdata = model_load(f, a, word);
            chk({tag, ".rdy"}, 32'(MIO_ready), 32'd1);
            chk({tag, ".err"}, 32'(mem_err), 32'(err_e));
            chk({tag, ".reqoff"}, 32'(bus_req), 32'd0);
            chk({tag, ".rdata"}, cpu_rdata, exp_rdata);
            cpu_req = 1'b0;
            @(negedge clk);
            chk({tag, ".pulse"}, 32'(MIO_ready), 32'd0);
        end
    endtask

    initial begin
        logic        r_we;
        logic [2:0]  r_f;
        logic [31:0] r_a;

        @(negedge clk);
        chk("rst.req", 32'(bus_req), 32'd0);
        chk("rst.rdy", 32'(MIO_ready), 32'd0);
        chk("rst.rdata", cpu_rdata, 32'd0);
        chk("rst.err", 32'(mem_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, "sb");
        access(1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h1234_8056, 0, "lb");
        chk("lb.const", cpu_rdata, 32'hFFFF_FF80);
        access(1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h1234_8056, 1, "lbu");
        chk("lbu.const", cpu_rdata, 32'h0000_0080);
        access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h1234_8056, 2, "lhu");
        chk("lhu.const", cpu_rdata, 32'h0000_1234);
        access(1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'h0, 0, "lw_mis");
        access(1'b1, 3'b001, 32'h0000_3001, 32'h0000_BEEF, 32'h0, 0, "sh_mis");
        access(1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 0, "illegal");
        access(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h5555_AAAA, -1, "timeout");
        chk("timeout.const", cpu_rdata, 32'h0);
        access(1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, TO - 1, "ack_at_to");
        chk("ack_at_to.const", cpu_rdata, 32'hCAFE_F00D);
        access(1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h0BAD_BEEF, 0, "b2b_0");
        access(1'b0, 3'b010, 32'h0000_6004, 32'h0, 32'h7EED_1234, 0, "b2b_1");

        for (int i = 0; i < 40; i++) begin
            r_we = 1'($urandom_range(0, 1));
            r_f  = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
            access(r_we, r_f, r_a, $urandom, $urandom, $urandom_range(0, 5), "rnd");
        end

        // Asynchronous reset in the middle of a pending bus cycle.
        access(1'b0, 3'b010, 32'h0000_7000, 32'h0, 32'hDEAD_BEEF, 1, "pre_rst");
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_fun3 = 3'b010; cpu_addr = 32'h0000_7004;
        @(negedge clk);
        chk("mid.req", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.req", 32'(bus_req), 32'd0);
        chk("arst.rdy", 32'(MIO_ready), 32'd0);
        chk("arst.rdata", cpu_rdata, 32'd0);
        cpu_req = 1'b0;
        exp_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post.req", 32'(bus_req), 32'd0);
        chk("post.rdy", 32'(MIO_ready), 32'd0);
        access(1'b0, 3'b001, 32'h0000_7002, 32'h0, 32'h8001_0000, 0, "post_lh");
        chk("post_lh.const", cpu_rdata, 32'hFFFF_8001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access sequencer placed directly downstream of the CPU control unit.
- Consumes the control unit's memory request (CPU_MIO), direction (MemRW) and Fun3 width code, then runs a req/ack handshake with the data bus or peripheral.
- Returns load data with sign/zero extension and raises MIO_ready when the access completes.
- Also handles store lane alignment, byte enables, misalignment detection and a bus timeout.

Parameters:
- ADDR_W, 32, address width.
- TIMEOUT, 255, bus cycles waited for ack before aborting with error; 0 disables the timeout.
- CNT_W, 8, timeout counter width; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  access request (CPU_MIO from control); held high until MIO_ready.
- cpu_we  in  1  1=store, 0=load (MemRW).
- cpu_fun3  in  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- cpu_addr  in  ADDR_W  byte address (ALU result).
- cpu_wdata  in  32  store data, right-aligned.
- cpu_rdata  out  32  extended load data.
- MIO_ready  out  1  one-cycle completion pulse.
- mem_err  out  1  valid with MIO_ready; misalign or timeout.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-shifted store data.
- bus_rdata  in  32  bus read word.
- bus_ack  in  1  bus completion; sampled only while bus_req=1.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs, latched fields and the counter are cleared to 0. A reset mid-transaction abandons it; bus_req drops immediately.
- All outputs are registered; nothing is combinational from the inputs.
- FSM states: IDLE, REQ, DONE.
- IDLE with cpu_req=1:
  - Latch cpu_we, cpu_fun3, cpu_addr, cpu_wdata.
  - Misaligned access (H/HU with addr[0]=1; W with addr[1:0]!=0) or illegal fun3 (011, 11x): go to DONE with mem_err=1. No bus cycle; stores write nothing.
  - Otherwise go to REQ and drive bus_req=1, bus_we, bus_addr={addr[ADDR_W-1:2],2'b00}, bus_be and bus_wdata from the next cycle.
- REQ:
  - Bus outputs are held stable.
  - bus_ack=1: capture bus_rdata (loads), drop bus_req, go to DONE with mem_err=0.
  - Else counter increments. If TIMEOUT!=0 and counter==TIMEOUT-1 with no ack: drop bus_req, go to DONE with mem_err=1, cpu_rdata=0.
  - Ack and timeout in the same cycle: ack wins.
- DONE: MIO_ready=1 for exactly one cycle; cpu_rdata and mem_err are valid that cycle. Go to IDLE.
- cpu_rdata holds its value until the next load completes.
- Minimum latency: cpu_req seen at edge 0, ack during first REQ cycle → MIO_ready high in cycle 2. Misaligned access → MIO_ready in cycle 1.
- cpu_req in DONE is ignored. cpu_req still high in the IDLE cycle after MIO_ready is treated as a new access; control must drop it if none is intended.
- Stores, with lane = addr[1:0]:
  - SB: be = 0001<<lane; wdata = {4{byte}}.
  - SH: be = 0011<<(2*addr[1]); wdata = {2{half}}.
  - SW: be = 1111.
- Loads: select byte by lane or halfword by addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through. For loads, bus_be follows the same pattern as stores and bus_wdata=0.
- Counter clears on entry to REQ.

Decomposition:
- Package cpu_mem_pkg:
  - FUN3_B/H/W/BU/HU constants.
  - State encoding ST_IDLE=2'd0, ST_REQ=2'd1, ST_DONE=2'd2.
  - Misalign predicate function.
- Sub-module mem_lane_align (combinational):
  - Store lane shift and byte enables.
  - Load select and extension.
  - Keeps the FSM file free of datapath logic.

Test Plan:
- Reset: rst_n low mid-REQ → bus_req=0, MIO_ready=0, cpu_rdata=0 immediately, asynchronously; after release, state is IDLE.
- SB addr=0x1003, wdata=0x000000A5, ack on first REQ cycle → bus_addr=0x1000, be=1000, bus_wdata=0xA5A5A5A5, MIO_ready in cycle 2, mem_err=0.
- LB addr=0x2001, bus_rdata=0x12348056 → cpu_rdata=0xFFFFFF80. LBU on the same word → 0x00000080. LHU addr=0x2002 → 0x00001234.
- LW addr=0x3002 → no bus_req, MIO_ready in cycle 1, mem_err=1. SH addr=0x3001 behaves the same.
- TIMEOUT=4, ack never asserted → bus_req high 4 cycles then low; MIO_ready=1, mem_err=1, cpu_rdata=0.
- Ack arriving exactly on the timeout cycle → mem_err=0, data captured. Back-to-back LW requests complete with exactly one MIO_ready each.
